// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op/state encodings and helpers for the HI/LO multiply-divide unit
package muldiv_pkg;
  localparam int W = 32;
  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } op_e;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;
  function automatic logic [W-1:0] mag(input logic [W-1:0] v, input logic sgn);
    return (sgn & v[W-1]) ? -v : v;
  endfunction
endpackage

// File: rtl/div_iter.sv
// div_iter: restoring divider on unsigned magnitudes, one quotient bit per step
module div_iter
  import muldiv_pkg::*;
(
  input  logic         clk,
  input  logic         resetn,
  input  logic         load,
  input  logic         step,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quot_nxt,
  output logic [W-1:0] rem_nxt
);
  logic [W-1:0] q, r, d;
  logic ge;
  // trial subtract of the shifted partial remainder; the low W bits of the difference are exact when it fits
  always_comb begin
    ge = {r, q[W-1]} >= {1'b0, d};
    quot_nxt = {q[W-2:0], ge};
    rem_nxt = ge ? {r[W-2:0], q[W-1]} - d : {r[W-2:0], q[W-1]};
  end
  // dividend shifts out of q as quotient bits shift in
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      q <= '0;
      r <= '0;
      d <= '0;
    end else if (load) begin
      q <= dividend;
      r <= '0;
      d <= divisor;
    end else if (step) begin
      q <= quot_nxt;
      r <= rem_nxt;
    end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: HI/LO register with single-cycle multiply and 32-step iterative divide
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  input  logic [2:0]    op,
  input  logic [W-1:0]  rs_data,
  input  logic [W-1:0]  rt_data,
  input  logic          flush,
  input  logic          stall_other,
  output logic          busy,
  output logic [2*W-1:0] hilo
);
  state_e state, state_nxt;
  logic [4:0] cnt;
  logic [W-1:0] a_q, b_q, quot_nxt, rem_nxt, quot_fix, rem_fix;
  logic sgn_q, is_mul, is_div, signed_op, go;
  logic [2*W-1:0] prod;
  assign is_mul = op == OP_MULT || op == OP_MULTU;
  assign is_div = op == OP_DIV || op == OP_DIVU;
  assign signed_op = op == OP_MULT || op == OP_DIV;
  assign go = state == S_IDLE && start && !flush;
  // sign-extending into 64 bits makes the low half of the unsigned product the signed product
  assign prod = {{W{sgn_q & a_q[W-1]}}, a_q} * {{W{sgn_q & b_q[W-1]}}, b_q};
  assign quot_fix = (sgn_q & (a_q[W-1] ^ b_q[W-1])) ? -quot_nxt : quot_nxt;
  assign rem_fix = (sgn_q & a_q[W-1]) ? -rem_nxt : rem_nxt;
  div_iter u_div (
    .clk      (clk),
    .resetn   (resetn),
    .load     (go & is_div),
    .step     (!flush && state == S_DIV),
    .dividend (mag(rs_data, signed_op)),
    .divisor  (mag(rt_data, signed_op)),
    .quot_nxt (quot_nxt),
    .rem_nxt  (rem_nxt)
  );
  // state register
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= S_IDLE;
    else state <= state_nxt;
  // next state; flush kills whatever is in flight
  always_comb
    state_nxt = flush ? S_IDLE :
                state == S_IDLE ? (start && is_mul ? S_MUL : start && is_div ? S_DIV : S_IDLE) :
                state == S_MUL ? S_DONE :
                state == S_DIV ? (cnt == 5'd31 ? S_DONE : S_DIV) :
                stall_other ? S_DONE : S_IDLE;
  // stall request; held low while in reset so a stray start cannot stall the pipe
  always_comb
    busy = resetn && (state == S_MUL || state == S_DIV || (state == S_IDLE && start && (is_mul || is_div)));
  // operand capture, iteration counter and HI/LO writes
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      cnt <= '0;
      a_q <= '0;
      b_q <= '0;
      sgn_q <= 1'b0;
      hilo <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else begin
      if (go && (is_mul || is_div)) begin
        a_q <= rs_data;
        b_q <= rt_data;
        sgn_q <= signed_op;
        cnt <= '0;
      end
      if (go && op == OP_MTHI) hilo[2*W-1:W] <= rs_data;
      if (go && op == OP_MTLO) hilo[W-1:0] <= rs_data;
      if (state == S_MUL) hilo <= prod;
      if (state == S_DIV) begin
        cnt <= cnt + 5'd1;
        if (cnt == 5'd31) hilo <= {rem_fix, quot_fix};
      end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: random and directed checks of muldiv_unit against an arithmetic reference
module tb_muldiv_unit;
  import muldiv_pkg::*;
  logic clk = 1'b0;
  logic resetn, start, flush, stall_other, busy;
  logic [2:0] op;
  logic [31:0] rs_data, rt_data;
  logic [63:0] hilo, m_hilo;
  int n_chk = 0, n_fail = 0;

  muldiv_unit dut (
    .clk         (clk),
    .resetn      (resetn),
    .start       (start),
    .op          (op),
    .rs_data     (rs_data),
    .rt_data     (rt_data),
    .flush       (flush),
    .stall_other (stall_other),
    .busy        (busy),
    .hilo        (hilo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_hilo(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                           input logic [63:0] prev);
    longint unsigned ua, ub;
    int sa, sb;
    ua = 64'(a);
    ub = 64'(b);
    sa = int'(a);
    sb = int'(b);
    case (o)
      3'd1: return 64'(longint'(sa) * longint'(sb));
      3'd2: return ua * ub;
      3'd3:
        if (b == 0) return {a, a[31] ? 32'd1 : 32'hFFFFFFFF};
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
        else return {32'(sa % sb), 32'(sa / sb)};
      3'd4: return (b == 0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
      3'd5: return {a, prev[31:0]};
      3'd6: return {prev[63:32], a};
      default: return prev;
    endcase
  endfunction

  // issue one op right after a falling edge, hold start while busy, then retire it
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    int n, exp_n;
    logic [63:0] e;
    e = ref_hilo(o, a, b, m_hilo);
    exp_n = (o == 3'd1 || o == 3'd2) ? 2 : (o == 3'd3 || o == 3'd4) ? 33 : 0;
    op = o;
    rs_data = a;
    rt_data = b;
    start = 1'b1;
    #1;
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
      #1;
    end
    if (exp_n == 0) begin
      @(negedge clk);
      #1;
    end
    check("busy_cycles", 64'(n), 64'(exp_n));
    check("hilo", hilo, e);
    m_hilo = e;
    start = 1'b0;
    op = 3'd0;
    @(negedge clk);
  endtask

  initial begin
    int n;
    logic [2:0] o;
    logic [31:0] a, b;
    resetn = 1'b0;
    start = 1'b1;
    op = 3'd1;
    rs_data = 32'h5;
    rt_data = 32'h7;
    flush = 1'b0;
    stall_other = 1'b0;
    m_hilo = '0;
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_hilo", hilo, 64'd0);
    repeat (2) @(negedge clk);
    start = 1'b0;
    resetn = 1'b1;
    @(negedge clk);

    run_op(3'd1, 32'hFFFFFFFE, 32'h00000003);
    check("mult_dir", hilo, 64'hFFFFFFFF_FFFFFFFA);
    run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check("multu_dir", hilo, 64'hFFFFFFFE_00000001);
    run_op(3'd3, 32'hFFFFFFF9, 32'h00000002);
    check("div_dir", hilo, 64'hFFFFFFFF_FFFFFFFD);
    run_op(3'd4, 32'h64, 32'h0);
    check("divu_zero", hilo, 64'h00000064_FFFFFFFF);
    run_op(3'd3, 32'h80000000, 32'hFFFFFFFF);
    check("div_ovf", hilo, 64'h00000000_80000000);
    run_op(3'd3, 32'hFFFFFF00, 32'h0);
    run_op(3'd3, 32'h00001234, 32'h0);
    run_op(3'd4, 32'hFFFFFFFF, 32'hFFFFFFFF);

    run_op(3'd5, 32'h1, 32'h0);
    run_op(3'd6, 32'h2, 32'h0);
    check("flush_pre", hilo, 64'h00000001_00000002);
    op = 3'd3;
    rs_data = 32'd1000;
    rt_data = 32'd7;
    start = 1'b1;
    repeat (11) @(negedge clk);
    flush = 1'b1;
    start = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_hilo", hilo, 64'h00000001_00000002);
    repeat (40) @(negedge clk);
    check("flush_late", hilo, 64'h00000001_00000002);

    op = 3'd1;
    rs_data = 32'hFFFFFFFE;
    rt_data = 32'h3;
    start = 1'b1;
    #1;
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
      #1;
    end
    check("stall_busy_cycles", 64'(n), 64'd2);
    stall_other = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("stall_hilo", hilo, 64'hFFFFFFFF_FFFFFFFA);
      @(negedge clk);
      #1;
      check("stall_busy", 64'(busy), 64'd0);
    end
    check("stall_hilo_end", hilo, 64'hFFFFFFFF_FFFFFFFA);
    stall_other = 1'b0;
    start = 1'b0;
    @(negedge clk);
    m_hilo = 64'hFFFFFFFF_FFFFFFFA;
    run_op(3'd5, 32'hAA, 32'h0);
    check("mthi_dir", hilo, 64'h000000AA_FFFFFFFA);

    op = 3'd4;
    rs_data = 32'd999;
    rt_data = 32'd10;
    start = 1'b1;
    repeat (5) @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_hilo", hilo, 64'd0);
    start = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    m_hilo = '0;
    repeat (40) @(negedge clk);
    check("rst_mid_late", hilo, 64'd0);
    run_op(3'd2, 32'h12345678, 32'h9);

    for (int i = 0; i < 60; i++) begin
      o = 3'($urandom_range(0, 7));
      a = ($urandom_range(0, 9) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: b = 32'hFFFFFFFF;
        2: b = 32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      run_op(o, a, b);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
